// File: rtl/dmem_responder_if.sv
// Load/store request channel and one-cycle response strobe
// between the CPU data port and the data-memory responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write_en;
  logic [2:0]  req_funct3;
  logic [31:0] req_write_data;
  logic        resp_valid;
  logic [31:0] resp_read_data;
  logic        resp_fault;

  modport master (
    output req_valid,
    input  req_ready,
    output req_addr,
    output req_write_en,
    output req_funct3,
    output req_write_data,
    input  resp_valid,
    input  resp_read_data,
    input  resp_fault
  );

  modport slave (
    input  req_valid,
    output req_ready,
    input  req_addr,
    input  req_write_en,
    input  req_funct3,
    input  req_write_data,
    output resp_valid,
    output resp_read_data,
    output resp_fault
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data RAM answering RV32I loads/stores with
// programmable access latency and fault reporting.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input logic           clk,
  input logic           reset,
  dmem_responder_if.slave bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [31:0] ADDR_LIM = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          go;

  logic [31:0] addr_q, wdat_q;
  logic        we_q;
  logic [2:0]  f3_q;

  logic [31:0] c_addr, c_wdat;
  logic        c_we;
  logic [2:0]  c_f3;

  logic        kind_ok, align_ok, legal;
  logic [AW-1:0] idx;
  logic [31:0] rword, ldata, wdata;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [3:0]  wmask;
  logic        wr_en;

  logic [31:0] rdata_q;
  logic        fault_q;

  logic [31:0] mem [DEPTH_WORDS];

  assign bus.req_ready      = (state == IDLE);
  assign bus.resp_valid     = (state == RESP);
  assign bus.resp_read_data = rdata_q;
  assign bus.resp_fault     = fault_q;

  // With no wait stage the access happens on the accept edge,
  // so the live request is used in IDLE and the latched one later.
  always_comb begin
    c_addr = addr_q;
    c_wdat = wdat_q;
    c_we   = we_q;
    c_f3   = f3_q;
    if (state == IDLE) begin
      c_addr = bus.req_addr;
      c_wdat = bus.req_write_data;
      c_we   = bus.req_write_en;
      c_f3   = bus.req_funct3;
    end
  end

  always_comb begin
    kind_ok  = 1'b1;
    align_ok = 1'b1;
    case (c_f3)
      3'b000: ;
      3'b001: align_ok = ~c_addr[0];
      3'b010: align_ok = (c_addr[1:0] == 2'b00);
      3'b100: kind_ok  = ~c_we;
      3'b101: begin
        kind_ok  = ~c_we;
        align_ok = ~c_addr[0];
      end
      default: kind_ok = 1'b0;
    endcase
    legal = kind_ok && align_ok && (c_addr < ADDR_LIM);
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    go      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (!legal || WAIT_CYCLES == 0) begin
            state_d = RESP;
            go      = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_d = RESP;
          go      = 1'b1;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req_valid) begin
      addr_q <= bus.req_addr;
      wdat_q <= bus.req_write_data;
      we_q   <= bus.req_write_en;
      f3_q   <= bus.req_funct3;
    end
  end

  assign idx   = c_addr[AW+1:2];
  assign rword = mem[idx];
  assign bsel  = rword[{c_addr[1:0], 3'b000} +: 8];
  assign hsel  = rword[{c_addr[1], 4'b0000} +: 16];

  always_comb begin
    ldata = '0;
    wdata = c_wdat;
    wmask = 4'b1111;
    case (c_f3)
      3'b000: begin
        ldata = {{24{bsel[7]}}, bsel};
        wdata = {4{c_wdat[7:0]}};
        wmask = 4'b0001 << c_addr[1:0];
      end
      3'b001: begin
        ldata = {{16{hsel[15]}}, hsel};
        wdata = {2{c_wdat[15:0]}};
        wmask = 4'b0011 << {c_addr[1], 1'b0};
      end
      3'b010:  ldata = rword;
      3'b100:  ldata = {24'b0, bsel};
      3'b101:  ldata = {16'b0, hsel};
      default: ldata = '0;
    endcase
  end

  assign wr_en = go && legal && c_we && !reset;

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_en && wmask[k])
        mem[idx][8*k +: 8] <= wdata[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else if (go) begin
      rdata_q <= (legal && !c_we) ? ldata : '0;
      fault_q <= ~legal;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: three responders (wait 1, 0, 3) driven
// through their interfaces, checked with immediate assertions.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        v   [3];
  logic        we  [3];
  logic [2:0]  f3  [3];
  logic [31:0] a   [3];
  logic [31:0] wd  [3];
  logic        rdy [3];
  logic        rv  [3];
  logic [31:0] rd  [3];
  logic        rf  [3];

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int W = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    dmem_responder_if bus();
    assign bus.req_valid      = v[g];
    assign bus.req_write_en   = we[g];
    assign bus.req_funct3     = f3[g];
    assign bus.req_addr       = a[g];
    assign bus.req_write_data = wd[g];
    assign rdy[g] = bus.req_ready;
    assign rv[g]  = bus.resp_valid;
    assign rd[g]  = bus.resp_read_data;
    assign rf[g]  = bus.resp_fault;
    dmem_responder #(
      .DEPTH_WORDS(256),
      .WAIT_CYCLES(W)
    ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs are scrambled right after acceptance to prove latching.
  task automatic req(input int w, input logic wr, input logic [2:0] f,
                     input logic [31:0] ad, input logic [31:0] d,
                     output logic [31:0] rdat, output logic flt,
                     output int lat);
    int n;
    v[w] = 1'b1; we[w] = wr; f3[w] = f; a[w] = ad; wd[w] = d;
    n = 0;
    while (!rdy[w] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    v[w] = 1'b0; a[w] = ad ^ 32'h0000_000C; wd[w] = ~d;
    lat = 2;
    while (!rv[w] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rdat = rd[w];
    flt  = rf[w];
    @(negedge clk);
  endtask

  task automatic access(input string tag, input int w, input logic wr,
                        input logic [2:0] f, input logic [31:0] ad,
                        input logic [31:0] d, input logic [31:0] ed,
                        input logic ef, input int el);
    logic [31:0] rdat;
    logic        flt;
    int          lat;
    req(w, wr, f, ad, d, rdat, flt, lat);
    chk({tag, ".data"}, rdat, ed);
    chk({tag, ".fault"}, {31'b0, flt}, {31'b0, ef});
    chk({tag, ".lat"}, 32'(lat), 32'(el));
  endtask

  task automatic spacing(input string tag, input int w, input int ex);
    int hits[3];
    int nh = 0;
    int nlow = 0;
    hits = '{-100, -100, -100};
    v[w] = 1'b1; we[w] = 1'b0; f3[w] = 3'b010;
    a[w] = 32'h10; wd[w] = 32'h0;
    for (int c = 0; c < 20 && nh < 3; c++) begin
      if (rdy[w]) begin
        hits[nh] = c;
        nh++;
      end else if (nh > 0) begin
        nlow++;
      end
      @(negedge clk);
    end
    v[w] = 1'b0;
    repeat (8) @(negedge clk);
    chk({tag, ".gap1"}, 32'(hits[1] - hits[0]), 32'(ex));
    chk({tag, ".gap2"}, 32'(hits[2] - hits[1]), 32'(ex));
    chk({tag, ".notready"}, 32'(nlow), 32'(2 * (ex - 1)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    int nresp;
    for (int i = 0; i < 3; i++) begin
      v[i] = 1'b0; we[i] = 1'b0; f3[i] = 3'b010;
      a[i] = '0; wd[i] = '0;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.ready", {31'b0, rdy[0]}, 32'd1);
    chk("rst.valid", {31'b0, rv[0]}, 32'd0);
    chk("rst.data", rd[0], 32'h0);
    chk("rst.fault", {31'b0, rf[0]}, 32'd0);
    chk("rst.ready2", {31'b0, rdy[2]}, 32'd1);
    reset = 1'b0;
    @(negedge clk);

    access("sw10", 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 3);
    access("lw10", 0, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3);
    access("sb11", 0, 1, 3'b000, 32'h11, 32'h000000AA, 32'h0, 0, 3);
    access("lw10b", 0, 0, 3'b010, 32'h10, 32'h0, 32'hDEADAAEF, 0, 3);
    access("lb11", 0, 0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFAA, 0, 3);
    access("lbu11", 0, 0, 3'b100, 32'h11, 32'h0, 32'h000000AA, 0, 3);
    access("lh12", 0, 0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 0, 3);
    access("lhu12", 0, 0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 0, 3);

    access("lw12mis", 0, 0, 3'b010, 32'h12, 32'h0, 32'h0, 1, 2);
    access("sh13mis", 0, 1, 3'b001, 32'h13, 32'h5555, 32'h0, 1, 2);
    access("lw400", 0, 0, 3'b010, 32'h400, 32'h0, 32'h0, 1, 2);
    access("f3_011", 0, 0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 2);
    access("st_f3_100", 0, 1, 3'b100, 32'h10, 32'h11, 32'h0, 1, 2);
    access("lw10c", 0, 0, 3'b010, 32'h10, 32'h0, 32'hDEADAAEF, 0, 3);

    spacing("b2b_w1", 0, 3);

    access("w0.sw0", 1, 1, 3'b010, 32'h0, 32'hA5A50F0F, 32'h0, 0, 2);
    access("w0.lh2", 1, 0, 3'b001, 32'h2, 32'h0, 32'hFFFFA5A5, 0, 2);
    spacing("b2b_w0", 1, 2);

    access("w3.sw20", 2, 1, 3'b010, 32'h20, 32'h11111111, 32'h0, 0, 5);
    v[2] = 1'b1; we[2] = 1'b1; f3[2] = 3'b010;
    a[2] = 32'h20; wd[2] = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    v[2] = 1'b0;
    chk("w3.inwait.ready", {31'b0, rdy[2]}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("w3.postrst.ready", {31'b0, rdy[2]}, 32'd1);
    chk("w3.postrst.valid", {31'b0, rv[2]}, 32'd0);
    nresp = 0;
    repeat (6) begin
      if (rv[2]) nresp++;
      @(negedge clk);
    end
    chk("w3.dropped.resp", 32'(nresp), 32'd0);
    access("w3.lw20", 2, 0, 3'b010, 32'h20, 32'h0, 32'h11111111, 0, 5);

    access("w3.sw28", 2, 1, 3'b010, 32'h28, 32'h0, 32'h0, 0, 5);
    access("w3.sw24", 2, 1, 3'b010, 32'h24, 32'hCAFEF00D, 32'h0, 0, 5);
    access("w3.lw24", 2, 0, 3'b010, 32'h24, 32'h0, 32'hCAFEF00D, 0, 5);
    access("w3.lw28", 2, 0, 3'b010, 32'h28, 32'h0, 32'h0, 0, 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
